vec_store_unit: RTL and testbench

VEC_STORE_UNIT -- requirements
Module: vec_store_unit

---
 rtl/vsu_pkg.sv | 24 ++
 rtl/vec_word_serializer.sv | 40 ++++
 rtl/vec_store_unit.sv | 103 ++++++++++
 tb/tb_vec_store_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsu_pkg.sv
// Shared constants, state encoding and helpers for the vector store unit.
// Optional feature macro used by the unit: VSU_STRIDE_EN (adds a stride input).
package vsu_pkg;

    localparam int VEC_W     = 512;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = VEC_W / WORD_W;
    localparam int REG_IDX_W = 2;
    localparam int ADDR_W    = 32;
    localparam int STRIDE_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } vsu_state_e;

    // Counter width that stays legal for a single-word vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_word_serializer.sv
// Holds the captured vector snapshot and walks it one memory word at a time.
// The word index only moves when the current word has been accepted.
module vec_word_serializer #(
    parameter int VEC_W  = vsu_pkg::VEC_W,
    parameter int WORD_W = vsu_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [VEC_W-1:0]  rf_read_data,
    output logic [WORD_W-1:0] word,
    output logic              last
);
    import vsu_pkg::*;

    localparam int NW    = VEC_W / WORD_W;
    localparam int IDX_W = idx_width(NW);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NW - 1);

    logic [NW-1:0][WORD_W-1:0] snapshot;
    logic [IDX_W-1:0]          k;

    // The index parks on the final word so word stays in range until the next load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snapshot <= '0;
            k        <= '0;
        end else if (load) begin
            snapshot <= rf_read_data;
            k        <= '0;
        end else if (advance && (k != LAST_K)) begin
            k <= k + IDX_W'(1);
        end
    end

    assign word = snapshot[k];
    assign last = (k == LAST_K);

endmodule

// File: rtl/vec_store_unit.sv
// Stores one vector register to memory as a stream of word writes with a valid/ready handshake.
// Optional: define VSU_STRIDE_EN to add an 8-bit word-stride input (otherwise stride is 1).
module vec_store_unit #(
    parameter int VEC_W  = vsu_pkg::VEC_W,
    parameter int WORD_W = vsu_pkg::WORD_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [vsu_pkg::REG_IDX_W-1:0] src_reg,
    input  logic [vsu_pkg::ADDR_W-1:0]    base_addr,
`ifdef VSU_STRIDE_EN
    input  logic [vsu_pkg::STRIDE_W-1:0]  stride,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [vsu_pkg::REG_IDX_W-1:0] rf_read_address,
    input  logic [VEC_W-1:0]              rf_read_data,
    output logic                          mem_valid,
    output logic [vsu_pkg::ADDR_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]             mem_wdata,
    input  logic                          mem_ready
);
    import vsu_pkg::*;

    vsu_state_e            state;
    logic [STRIDE_W-1:0]   stride_q;
    logic                  load;
    logic                  accept;
    logic                  last_word;

    assign load   = (state == FETCH);
    assign accept = mem_valid && mem_ready;

`ifndef VSU_STRIDE_EN
    assign stride_q = STRIDE_W'(1);
`endif

    vec_word_serializer #(
        .VEC_W  (VEC_W),
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .advance      (accept),
        .rf_read_data (rf_read_data),
        .word         (mem_wdata),
        .last         (last_word)
    );

    // mem_addr is loaded with the base at start and stepped only on an accepted word,
    // so address and data stay frozen while the memory stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_valid       <= 1'b0;
            mem_addr        <= '0;
            rf_read_address <= '0;
`ifdef VSU_STRIDE_EN
            stride_q        <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state           <= FETCH;
                        busy            <= 1'b1;
                        rf_read_address <= src_reg;
                        mem_addr        <= base_addr;
`ifdef VSU_STRIDE_EN
                        stride_q        <= stride;
`endif
                    end
                end
                FETCH: begin
                    state     <= STREAM;
                    mem_valid <= 1'b1;
                end
                STREAM: begin
                    if (mem_ready) begin
                        if (last_word) begin
                            state     <= DONE;
                            mem_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + {{(ADDR_W-STRIDE_W){1'b0}}, stride_q};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_unit.sv
// Self-checking bench for vec_store_unit with a behavioural register file and transfer model.
module tb_vec_store_unit;

    localparam int NW = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   src_reg;
    logic [31:0]  base_addr;
`ifdef VSU_STRIDE_EN
    logic [7:0]   stride;
`endif
    logic         busy;
    logic         done;
    logic [1:0]   rf_read_address;
    logic [511:0] rf_read_data;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;

    logic [511:0] rf [4];
    assign rf_read_data = rf[rf_read_address];

    always #5 clk = ~clk;

    vec_store_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .src_reg         (src_reg),
        .base_addr       (base_addr),
`ifdef VSU_STRIDE_EN
        .stride          (stride),
`endif
        .busy            (busy),
        .done            (done),
        .rf_read_address (rf_read_address),
        .rf_read_data    (rf_read_data),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observations of one transfer, filled by drive_store.
    logic [31:0] got_addr [NW];
    logic [31:0] got_data [NW];
    int   n_acc, first_vld, done_cyc, done_cnt, hold_err, extra_vld;
    logic busy_at1, busy_post;

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [7:0] strd, input int i);
        return base + 32'(i) * {24'd0, strd};
    endfunction

    // Issues one start and records every accepted word plus timing; cycle c counts edges since start.
    task automatic drive_store(input logic [1:0] src, input logic [31:0] base, input logic [7:0] strd,
                               input int rmode, input int mut_cyc, input int busy_start_cyc);
        logic r, pv, pr;
        logic [31:0] pa, pd;
        n_acc = 0; first_vld = -1; done_cyc = -1; done_cnt = 0; hold_err = 0; extra_vld = 0;
        busy_at1 = 1'b0; busy_post = 1'b1;
        pv = 1'b0; pr = 1'b0; pa = '0; pd = '0;
        @(negedge clk);
        src_reg = src; base_addr = base; start = 1'b1; mem_ready = 1'b0;
`ifdef VSU_STRIDE_EN
        stride = strd;
`endif
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            src_reg = 2'($urandom);
            base_addr = $urandom;
`ifdef VSU_STRIDE_EN
            stride = 8'($urandom);
`endif
            if (c == busy_start_cyc) start = 1'b1;
            if (c == mut_cyc) rf[src] = rand_vec();
            if (c == 1) busy_at1 = busy;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_post = busy;
            if (mem_valid && first_vld < 0) first_vld = c;
            if (pv && !pr && (mem_valid !== 1'b1 || mem_addr !== pa || mem_wdata !== pd)) hold_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && mem_valid === 1'b1) extra_vld++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = c[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            mem_ready = r;
            if (mem_valid === 1'b1 && r) begin
                if (n_acc < NW) begin
                    got_addr[n_acc] = mem_addr;
                    got_data[n_acc] = mem_wdata;
                end
                n_acc++;
            end
            pv = mem_valid; pr = r; pa = mem_addr; pd = mem_wdata;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mem_ready = 1'b0; src_reg = 2'd3; base_addr = 32'hDEAD_BEEF;
`ifdef VSU_STRIDE_EN
        stride = 8'd1;
`endif
        for (int i = 0; i < 4; i++) rf[i] = rand_vec();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (mem_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", mem_valid); end
        n_checks++; if (mem_addr !== 32'd0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (rf_read_address !== 2'd0) begin n_errors++; $display("FAIL reset_rfaddr: got %0d want 0", rf_read_address); end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [511:0] snap;
        for (int i = 0; i < NW; i++) rf[2][i*32 +: 32] = 32'h100 + 32'(i);
        snap = rf[2];
        drive_store(2'd2, 32'h1000, 8'd1, 0, -1, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL basic_count: got %0d want %0d", n_acc, NW); end
        n_checks++; if (busy_at1 !== 1'b1) begin n_errors++; $display("FAIL basic_busy_fetch: got %b want 1", busy_at1); end
        n_checks++; if (first_vld != 2) begin n_errors++; $display("FAIL basic_first_valid: got cycle %0d want 2", first_vld); end
        n_checks++; if (done_cyc != 18) begin n_errors++; $display("FAIL basic_done_cycle: got %0d want 18", done_cyc); end
        n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (extra_vld != 0) begin n_errors++; $display("FAIL basic_valid_in_done: got %0d want 0", extra_vld); end
        n_checks++; if (busy_post !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after: got %b want 0", busy_post); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_addr[i] !== 32'h1000 + 32'(i) || got_data[i] !== snap[i*32 +: 32]) begin
                n_errors++;
                $display("FAIL basic_word%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, got_addr[i], got_data[i], 32'h1000 + 32'(i), snap[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] snap;
        logic [31:0]  base;
        rf[1] = rand_vec();
        snap = rf[1];
        base = $urandom;
        drive_store(2'd1, base, 8'd1, 1, -1, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL bp_count: got %0d want %0d", n_acc, NW); end
        n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err); end
        n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr(base, 8'd1, i) || got_data[i] !== snap[i*32 +: 32]) begin
                n_errors++;
                $display("FAIL bp_word%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, got_addr[i], got_data[i], exp_addr(base, 8'd1, i), snap[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [511:0] snap;
        rf[3] = rand_vec();
        snap = rf[3];
        drive_store(2'd3, 32'h0000_4000, 8'd1, 2, 4, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL snap_count: got %0d want %0d", n_acc, NW); end
        n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL snap_hold: got %0d want 0", hold_err); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_data[i] !== snap[i*32 +: 32]) begin
                n_errors++;
                $display("FAIL snap_word%0d: got data=%h want %h", i, got_data[i], snap[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [511:0] snap;
        rf[0] = rand_vec();
        snap = rf[0];
        drive_store(2'd0, 32'hFFFF_FFFE, 8'd1, 0, -1, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL wrap_count: got %0d want %0d", n_acc, NW); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr(32'hFFFF_FFFE, 8'd1, i) || got_data[i] !== snap[i*32 +: 32]) begin
                n_errors++;
                $display("FAIL wrap_word%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, got_addr[i], got_data[i], exp_addr(32'hFFFF_FFFE, 8'd1, i), snap[i*32 +: 32]);
            end
        end
        n_checks++; if (got_addr[2] !== 32'h0) begin n_errors++; $display("FAIL wrap_zero: got %h want 0", got_addr[2]); end
    endtask

`ifdef VSU_STRIDE_EN
    task automatic test_stride();
        drive_store(2'd1, 32'h0, 8'd4, 0, -1, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL stride4_count: got %0d want %0d", n_acc, NW); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_addr[i] !== 32'(4 * i)) begin
                n_errors++;
                $display("FAIL stride4_addr%0d: got %h want %h", i, got_addr[i], 32'(4 * i));
            end
        end
        drive_store(2'd1, 32'h0000_0ABC, 8'd0, 2, -1, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL stride0_count: got %0d want %0d", n_acc, NW); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_addr[i] !== 32'h0000_0ABC) begin
                n_errors++;
                $display("FAIL stride0_addr%0d: got %h want 00000abc", i, got_addr[i]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [511:0] snap;
        int seen;
        rf[0] = rand_vec();
        snap = rf[0];
        @(negedge clk);
        src_reg = 2'd0; base_addr = 32'h2000; start = 1'b1; mem_ready = 1'b1;
`ifdef VSU_STRIDE_EN
        stride = 8'd1;
`endif
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h2006 || mem_wdata !== snap[6*32 +: 32]) begin
            n_errors++;
            $display("FAIL rst_pre_word6: got valid=%b addr=%h data=%h want 1 00002006 %h",
                     mem_valid, mem_addr, mem_wdata, snap[6*32 +: 32]);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid: got %b want 0", mem_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_async_done: got %b want 0", done); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (mem_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen++;
        end
        mem_ready = 1'b0;
        n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", seen); end
        drive_store(2'd0, 32'h2000, 8'd1, 0, -1, -1);
        n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL rst_restart_count: got %0d want %0d", n_acc, NW); end
        n_checks++; if (first_vld != 2) begin n_errors++; $display("FAIL rst_restart_latency: got %0d want 2", first_vld); end
        for (int i = 0; i < NW && i < n_acc; i++) begin
            n_checks++;
            if (got_addr[i] !== 32'h2000 + 32'(i) || got_data[i] !== snap[i*32 +: 32]) begin
                n_errors++;
                $display("FAIL rst_restart_word%0d: got addr=%h data=%h want addr=%h data=%h",
                         i, got_addr[i], got_data[i], 32'h2000 + 32'(i), snap[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [511:0] snap;
        int pulse_cyc [2];
        pulse_cyc[0] = 6;
        pulse_cyc[1] = 18;
        for (int t = 0; t < 2; t++) begin
            rf[2] = rand_vec();
            snap = rf[2];
            drive_store(2'd2, 32'h0000_8000, 8'd1, 0, -1, pulse_cyc[t]);
            n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL busy_start%0d_done: got %0d want 1", t, done_cnt); end
            n_checks++; if (extra_vld != 0) begin n_errors++; $display("FAIL busy_start%0d_restart: got %0d valid cycles want 0", t, extra_vld); end
            n_checks++; if (busy_post !== 1'b0) begin n_errors++; $display("FAIL busy_start%0d_busy: got %b want 0", t, busy_post); end
            n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL busy_start%0d_count: got %0d want %0d", t, n_acc, NW); end
            for (int i = 0; i < NW && i < n_acc; i++) begin
                n_checks++;
                if (got_addr[i] !== 32'h8000 + 32'(i) || got_data[i] !== snap[i*32 +: 32]) begin
                    n_errors++;
                    $display("FAIL busy_start%0d_word%0d: got addr=%h data=%h want addr=%h data=%h",
                             t, i, got_addr[i], got_data[i], 32'h8000 + 32'(i), snap[i*32 +: 32]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [511:0] snap;
        logic [31:0]  base;
        logic [7:0]   strd;
        logic [1:0]   src;
        for (int t = 0; t < 4; t++) begin
            src  = 2'($urandom);
            base = $urandom;
`ifdef VSU_STRIDE_EN
            strd = 8'($urandom);
`else
            strd = 8'd1;
`endif
            rf[src] = rand_vec();
            snap = rf[src];
            drive_store(src, base, strd, 2, 3 + int'($urandom_range(0, 10)), -1);
            n_checks++; if (n_acc != NW) begin n_errors++; $display("FAIL rand%0d_count: got %0d want %0d", t, n_acc, NW); end
            n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL rand%0d_hold: got %0d want 0", t, hold_err); end
            n_checks++; if (done_cnt != 1) begin n_errors++; $display("FAIL rand%0d_done: got %0d want 1", t, done_cnt); end
            for (int i = 0; i < NW && i < n_acc; i++) begin
                n_checks++;
                if (got_addr[i] !== exp_addr(base, strd, i) || got_data[i] !== snap[i*32 +: 32]) begin
                    n_errors++;
                    $display("FAIL rand%0d_word%0d: got addr=%h data=%h want addr=%h data=%h",
                             t, i, got_addr[i], got_data[i], exp_addr(base, strd, i), snap[i*32 +: 32]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_wrap();
`ifdef VSU_STRIDE_EN
        test_stride();
`endif
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
